// File: rtl/datapath_sequencer.sv
// rtl/datapath_sequencer.sv - control-word microsequencer for the 4-bit register-file/ALU datapath
module datapath_sequencer #(
    parameter int PROG_DEPTH = 8,
    parameter int ADDR_W     = 3,
    parameter int CW_W       = 13
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [CW_W-1:0]   prog_data,
    input  logic              start,
    input  logic              alu_cout,
    output logic              busy,
    output logic              done,
    output logic              prog_err,
    output logic [ADDR_W-1:0] pc,
    output logic [1:0]        A_addr,
    output logic [1:0]        B_addr,
    output logic [1:0]        D_addr,
    output logic              nWE,
    output logic              alu_sel,
    output logic [1:0]        func_sel,
    output logic              C_in,
    output logic              carry_flag
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_WB,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PROG_DEPTH - 1);

    state_t state_q, state_d;

    logic [CW_W-1:0]   mem_q [PROG_DEPTH];
    logic              mem_we;

    logic [CW_W-1:0]   ir_q, ir_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_out_q, pc_out_d;
    logic              carry_q, carry_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [1:0]        a_q, a_d;
    logic [1:0]        b_q, b_d;
    logic [1:0]        d_q, d_d;
    logic              nwe_q, nwe_d;
    logic              alu_q, alu_d;
    logic [1:0]        func_q, func_d;
    logic              cin_q, cin_d;

    // Each control output is the registered image of the value its state computes,
    // so the datapath sees a word's controls one cycle after the state that owns them.
    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        pc_d     = pc_q;
        pc_out_d = pc_q;
        carry_d  = carry_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = prog_we && (state_q != S_IDLE);
        mem_we   = prog_we && (state_q == S_IDLE);
        a_d      = a_q;
        b_d      = b_q;
        d_d      = d_q;
        nwe_d    = 1'b1;
        alu_d    = alu_q;
        func_d   = func_q;
        cin_d    = cin_q;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    pc_d    = '0;
                    carry_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                ir_d    = mem_q[pc_q];
                busy_d  = 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                a_d     = ir_q[7:6];
                b_d     = ir_q[5:4];
                d_d     = ir_q[9:8];
                alu_d   = ir_q[3];
                func_d  = ir_q[2:1];
                cin_d   = ir_q[12] ? carry_q : ir_q[0];
                state_d = S_WB;
            end
            S_WB: begin
                nwe_d   = ~ir_q[10];
                carry_d = alu_cout;
                if (ir_q[11] || (pc_q == LAST_ADDR)) begin
                    state_d = S_DONE;
                end else begin
                    pc_d    = pc_q + 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nRST) begin
            state_q  <= S_IDLE;
            ir_q     <= '0;
            pc_q     <= '0;
            pc_out_q <= '0;
            carry_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            d_q      <= '0;
            nwe_q    <= 1'b1;
            alu_q    <= 1'b0;
            func_q   <= '0;
            cin_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            pc_q     <= pc_d;
            pc_out_q <= pc_out_d;
            carry_q  <= carry_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            a_q      <= a_d;
            b_q      <= b_d;
            d_q      <= d_d;
            nwe_q    <= nwe_d;
            alu_q    <= alu_d;
            func_q   <= func_d;
            cin_q    <= cin_d;
        end
    end

    // Program memory survives reset; only writes during reset are blocked.
    always_ff @(posedge clk) begin
        if (nRST && mem_we) begin
            mem_q[prog_addr] <= prog_data;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign prog_err   = err_q;
    assign pc         = pc_out_q;
    assign A_addr     = a_q;
    assign B_addr     = b_q;
    assign D_addr     = d_q;
    assign nWE        = nwe_q;
    assign alu_sel    = alu_q;
    assign func_sel   = func_q;
    assign C_in       = cin_q;
    assign carry_flag = carry_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// tb/tb_datapath_sequencer.sv - self-checking bench for datapath_sequencer
module tb_datapath_sequencer;

    logic        clk = 1'b0;
    logic        nRST, prog_we, start, alu_cout;
    logic [2:0]  prog_addr;
    logic [12:0] prog_data;
    logic        busy, done, prog_err, nWE, alu_sel, C_in, carry_flag;
    logic [2:0]  pc;
    logic [1:0]  A_addr, B_addr, D_addr, func_sel;

    always #5 clk = ~clk;

    datapath_sequencer #(.PROG_DEPTH(8), .ADDR_W(3), .CW_W(13)) dut (
        .clk(clk), .nRST(nRST), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .start(start), .alu_cout(alu_cout),
        .busy(busy), .done(done), .prog_err(prog_err), .pc(pc),
        .A_addr(A_addr), .B_addr(B_addr), .D_addr(D_addr), .nWE(nWE),
        .alu_sel(alu_sel), .func_sel(func_sel), .C_in(C_in), .carry_flag(carry_flag)
    );

    int checks = 0;
    int failures = 0;
    logic [12:0] mdl_mem [8];

    typedef struct {
        logic       nwe;
        logic       bsy;
        logic       dn;
        logic [2:0] pcv;
        logic       ctl;
        logic [1:0] a;
        logic [1:0] d;
        logic       cin;
    } vec_t;
    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic load(input logic [2:0] a, input logic [12:0] d, input logic with_start);
        prog_we = 1'b1; prog_addr = a; prog_data = d; start = with_start;
        tick;
        prog_we = 1'b0; start = 1'b0;
        mdl_mem[a] = d;
    endtask

    // Expected trace is derived from the program: word i occupies cycles 3i+1..3i+3
    // after the accept edge, done lands on 3N+1.
    task automatic run_prog(input int cout_mode, input int inj_mode);
        logic [12:0] w [8];
        bit          cv [64];
        int          n, inj, i, ph, j;
        logic        exp_cf, exp_cin;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            w[k] = mdl_mem[k];
            n = k + 1;
            if (w[k][11]) break;
        end
        for (int k = 0; k < 64; k++) cv[k] = (cout_mode < 0) ? 1'($urandom % 2) : cout_mode[0];
        inj = (inj_mode == 0) ? 1 + int'($urandom % (3 * n)) : inj_mode;
        start = 1'b1;
        tick;
        start = 1'b0;
        alu_cout = cv[0];
        for (int t = 1; t <= 3 * n + 2; t++) begin
            tick;
            i  = (t - 1) / 3;
            ph = (t - 1) % 3;
            chk($sformatf("busy t%0d", t), busy, t <= 3 * n);
            chk($sformatf("done t%0d", t), done, t == 3 * n + 1);
            chk($sformatf("pc t%0d", t), pc, (i < n) ? i : n - 1);
            chk($sformatf("nWE t%0d", t), nWE, !(ph == 2 && i < n && w[i][10]));
            chk($sformatf("prog_err t%0d", t), prog_err, inj > 0 && t == inj + 1);
            if (t < 3) exp_cf = 1'b0;
            else begin
                j = t / 3 - 1;
                if (j > n - 1) j = n - 1;
                exp_cf = cv[3 * j + 2];
            end
            chk($sformatf("carry_flag t%0d", t), carry_flag, exp_cf);
            if (i < n && ph != 0) begin
                exp_cin = w[i][12] ? ((i == 0) ? 1'b0 : cv[3 * i - 1]) : w[i][0];
                chk($sformatf("A_addr t%0d", t), A_addr, w[i][7:6]);
                chk($sformatf("B_addr t%0d", t), B_addr, w[i][5:4]);
                chk($sformatf("D_addr t%0d", t), D_addr, w[i][9:8]);
                chk($sformatf("alu_sel t%0d", t), alu_sel, w[i][3]);
                chk($sformatf("func_sel t%0d", t), func_sel, w[i][2:1]);
                chk($sformatf("C_in t%0d", t), C_in, exp_cin);
            end
            if (inj > 0 && t == inj) begin
                prog_we = 1'b1; prog_addr = 3'd0; prog_data = 13'h1FFF; start = 1'b1;
            end else begin
                prog_we = 1'b0; start = 1'b0;
            end
            alu_cout = cv[t];
        end
    endtask

    initial begin
        nRST = 1'b0; prog_we = 1'b0; start = 1'b0; alu_cout = 1'b0;
        prog_addr = '0; prog_data = '0;

        for (int k = 0; k < 2; k++) begin
            start = 1'($urandom); alu_cout = 1'($urandom);
            prog_addr = 3'($urandom); prog_data = 13'($urandom);
            tick;
        end
        chk("rst busy", busy, 1'b0);
        chk("rst done", done, 1'b0);
        chk("rst prog_err", prog_err, 1'b0);
        chk("rst pc", pc, 3'd0);
        chk("rst A_addr", A_addr, 2'd0);
        chk("rst B_addr", B_addr, 2'd0);
        chk("rst D_addr", D_addr, 2'd0);
        chk("rst nWE", nWE, 1'b1);
        chk("rst alu_sel", alu_sel, 1'b0);
        chk("rst func_sel", func_sel, 2'd0);
        chk("rst C_in", C_in, 1'b0);
        chk("rst carry_flag", carry_flag, 1'b0);
        nRST = 1'b1; start = 1'b0; alu_cout = 1'b0;
        tick;

        //            nwe  bsy  dn   pc    ctl  a     d     cin
        tbl[0] = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 2'd0, 2'd0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 2'd3, 2'd0, 1'b1};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 2'd3, 2'd0, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 2'd0, 2'd0, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 3'd1, 1'b1, 2'd0, 2'd1, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 3'd1, 1'b1, 2'd0, 2'd1, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 2'd0, 2'd0, 1'b0};
        load(3'd1, 13'h0D00, 1'b0);
        load(3'd0, 13'h04E5, 1'b1);
        for (int k = 0; k < 7; k++) begin
            tick;
            chk($sformatf("tbl nWE c%0d", k + 1), nWE, tbl[k].nwe);
            chk($sformatf("tbl busy c%0d", k + 1), busy, tbl[k].bsy);
            chk($sformatf("tbl done c%0d", k + 1), done, tbl[k].dn);
            chk($sformatf("tbl pc c%0d", k + 1), pc, tbl[k].pcv);
            if (tbl[k].ctl) begin
                chk($sformatf("tbl A_addr c%0d", k + 1), A_addr, tbl[k].a);
                chk($sformatf("tbl D_addr c%0d", k + 1), D_addr, tbl[k].d);
                chk($sformatf("tbl C_in c%0d", k + 1), C_in, tbl[k].cin);
            end
        end
        tick;

        for (int k = 0; k < 8; k++) load(3'(k), (13'($urandom) & 13'h13FF) | 13'h0400, 1'b0);
        run_prog(-1, -1);
        run_prog(-1, 1);
        run_prog(-1, -1);

        load(3'd0, 13'h0400, 1'b0);
        load(3'd1, 13'h1C00, 1'b0);
        run_prog(1, -1);
        run_prog(0, -1);

        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        nRST = 1'b0;
        tick;
        chk("midrst nWE", nWE, 1'b1);
        chk("midrst busy", busy, 1'b0);
        chk("midrst pc", pc, 3'd0);
        chk("midrst done", done, 1'b0);
        chk("midrst carry_flag", carry_flag, 1'b0);
        nRST = 1'b1;
        tick;
        run_prog(-1, -1);

        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 8; k++) begin
                prog_data = 13'($urandom);
                if ($urandom % 4 != 0) prog_data[11] = 1'b0;
                load(3'(k), prog_data, 1'b0);
            end
            run_prog(-1, (r % 2 == 1) ? 0 : -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
